// File: rtl/wide_add_sequencer_if.sv
// Operand/result handshake bundle for wide_add_sequencer.
// The operand source drives the master side; the sequencer is the slave.
interface wide_add_sequencer_if #(
   parameter int unsigned NUM_SLICES = 4
);
   localparam int unsigned DATA_W = 16 * NUM_SLICES;

   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] a;
   logic [DATA_W-1:0] b;
   logic              sub;
   logic              cin;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] sum;
   logic              cout;
   logic              ovf;
   logic              busy;

   modport master (
      output in_valid, a, b, sub, cin, out_ready,
      input  in_ready, out_valid, sum, cout, ovf, busy
   );

   modport slave (
      input  in_valid, a, b, sub, cin, out_ready,
      output in_ready, out_valid, sum, cout, ovf, busy
   );
endinterface

// File: rtl/wide_add_sequencer.sv
// Multi-cycle wide add/sub that reuses one 16-bit carry-skip adder.
// One slice per clock, LSB first, with the carry held in a register between slices.
module carry_skip_16bit (
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        cin,
   output logic [15:0] sum,
   output logic        cout
);
   logic [15:0] p;
   logic [4:0]  blk_c;
   logic        c;

   // Four 4-bit ripple blocks; a fully propagating block forwards its carry-in directly
   always_comb begin
      p        = a ^ b;
      sum      = '0;
      blk_c    = '0;
      blk_c[0] = cin;
      c        = 1'b0;
      for (int k = 0; k < 4; k++) begin
         c = blk_c[k];
         for (int j = 0; j < 4; j++) begin
            sum[4*k+j] = p[4*k+j] ^ c;
            c          = (a[4*k+j] & b[4*k+j]) | (p[4*k+j] & c);
         end
         blk_c[k+1] = (&p[4*k +: 4]) ? blk_c[k] : c;
      end
      cout = blk_c[4];
   end
endmodule

module wide_add_sequencer #(
   parameter int unsigned NUM_SLICES = 4
) (
   input logic                clk,
   input logic                rst,
   wide_add_sequencer_if.slave bus
);
   localparam int unsigned DATA_W = 16 * NUM_SLICES;
   localparam int unsigned IDX_W  = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLICES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state;
   logic [IDX_W-1:0]  idx;
   logic              carry;
   logic [DATA_W-1:0] a_reg;
   logic [DATA_W-1:0] b_reg;

   logic [15:0] add_a;
   logic [15:0] add_b;
   logic [15:0] add_s;
   logic        add_co;

   assign add_a = a_reg[{idx, 4'b0000} +: 16];
   assign add_b = b_reg[{idx, 4'b0000} +: 16];

   carry_skip_16bit u_add (
      .a    (add_a),
      .b    (add_b),
      .cin  (carry),
      .sum  (add_s),
      .cout (add_co)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         idx           <= '0;
         carry         <= 1'b0;
         a_reg         <= '0;
         b_reg         <= '0;
         bus.sum       <= '0;
         bus.cout      <= 1'b0;
         bus.ovf       <= 1'b0;
         bus.out_valid <= 1'b0;
         bus.busy      <= 1'b0;
         bus.in_ready  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               bus.in_ready <= 1'b1;
               if (bus.in_valid && bus.in_ready) begin
                  // Subtraction is a + ~b + 1, so the operand is inverted at capture
                  a_reg        <= bus.a;
                  b_reg        <= bus.sub ? ~bus.b : bus.b;
                  carry        <= bus.sub ? 1'b1 : bus.cin;
                  idx          <= '0;
                  bus.in_ready <= 1'b0;
                  bus.busy     <= 1'b1;
                  state        <= RUN;
               end
            end
            RUN: begin
               bus.sum[{idx, 4'b0000} +: 16] <= add_s;
               carry                         <= add_co;
               if (idx == LAST_IDX) begin
                  bus.cout      <= add_co;
                  bus.ovf       <= (a_reg[DATA_W-1] == b_reg[DATA_W-1]) &
                                   (add_s[15] != a_reg[DATA_W-1]);
                  bus.out_valid <= 1'b1;
                  state         <= DONE;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  bus.out_valid <= 1'b0;
                  bus.busy      <= 1'b0;
                  bus.in_ready  <= 1'b1;
                  state         <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/wide_add_sequencer.md
Name: wide_add_sequencer

Overview:
- Multi-cycle wide adder/subtractor built around one shared carry_skip_16bit instance.
- Processes one 16-bit slice per clock, LSB slice first, with the carry registered between slices.
- Gives DATA_W = 16*NUM_SLICES add/sub without replicating adder hardware.
- Valid/ready on both sides; sits between an operand source and a result consumer.

Parameters:
- NUM_SLICES, 4, number of 16-bit slices; legal 1..8; DATA_W = 16*NUM_SLICES.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand request valid.
- in_ready  output  1  sequencer can accept an operation.
- a  input  DATA_W  operand A.
- b  input  DATA_W  operand B.
- sub  input  1  0 = a+b+cin; 1 = a-b (computed as a + ~b + 1; cin ignored).
- cin  input  1  carry-in for add.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- sum  output  DATA_W  result, modulo 2^DATA_W.
- cout  output  1  carry out of MSB; for sub, 1 = no borrow (a >= b unsigned).
- ovf  output  1  two's-complement signed overflow.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset: state=IDLE, slice index=0, carry reg=0, sum=0, cout=0, ovf=0, out_valid=0, busy=0. in_ready=0 while rst is high; in_ready=1 from the first cycle after rst deasserts.
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1.
  - When in_valid & in_ready at an edge: capture a into a_reg; capture b_eff = sub ? ~b : b into b_reg; carry reg = sub ? 1 : cin; idx=0; go to RUN.
- RUN: in_ready=0. The adder sees a_reg[16*idx +: 16], b_reg slice, and carry reg.
  - Each edge: write the adder sum into sum[16*idx +: 16]; carry reg = adder cout; idx++.
  - On the edge writing slice NUM_SLICES-1: latch cout = adder cout, compute ovf, go to DONE.
- ovf rule: ovf = (a_reg[MSB] == b_reg[MSB]) & (sum[MSB] != a_reg[MSB]), using b_reg after inversion.
- Latency: out_valid rises exactly NUM_SLICES clocks after the accepting edge (4 for the default).
- DONE: out_valid=1; sum, cout and ovf are held stable until out_valid & out_ready at an edge, then go to IDLE.
  - Throughput: one operation per NUM_SLICES+2 cycles.
- sum bits of slices not yet written in RUN hold the previous result. The consumer samples sum only while out_valid is high.
- in_valid while in_ready=0 is ignored; no queuing.
- Operand inputs may change after the accepting edge; the result depends only on the captured values.
- out_ready while out_valid=0 is ignored.
- Reset mid-RUN or mid-DONE: the operation is dropped immediately (asynchronously), no out_valid is produced, and all outputs take reset values.
- NUM_SLICES=1: RUN lasts one cycle, latency 1.
- Slice index width is clog2(NUM_SLICES), minimum 1 bit. idx never exceeds NUM_SLICES-1; no wrap occurs.

Test Plan:
All cases use NUM_SLICES=4, DATA_W=64.
1. Cross-slice carry: add a=0x0000_0000_0000_FFFF, b=0x1, cin=0, out_ready=1 -> out_valid exactly 4 clocks after accept; sum=0x0000_0000_0001_0000, cout=0, ovf=0; in_ready returns to 1 one cycle after the output handshake.
2. Full carry chain and skip path:
   - a=0xFFFF_FFFF_FFFF_FFFF, b=0x1, cin=0 -> sum=0, cout=1, ovf=0.
   - a=0xAAAA_AAAA_AAAA_AAAA, b=0x5555_5555_5555_5555, cin=1 -> sum=0, cout=1.
3. Subtract:
   - sub=1, a=5, b=7, cin=1 -> sum=0xFFFF_FFFF_FFFF_FFFE, cout=0, ovf=0 (cin ignored).
   - sub=1, a=7, b=5 -> sum=2, cout=1.
4. Signed overflow:
   - add 0x7FFF_FFFF_FFFF_FFFF + 1 -> sum=0x8000_0000_0000_0000, ovf=1, cout=0.
   - sub 0x8000_0000_0000_0000 - 1 -> sum=0x7FFF_FFFF_FFFF_FFFF, ovf=1, cout=1.
5. Backpressure and ignored requests:
   - Hold out_ready=0 for 10 cycles after out_valid -> out_valid, sum, cout and ovf stay stable; in_ready=0 and busy=1 throughout.
   - in_valid pulsed with new operands during RUN and DONE -> no effect on the current result.
   - Release out_ready -> exactly one transfer.
6. Reset mid-operation: assert rst asynchronously after the 2nd RUN slice -> out_valid, busy, sum and cout go to 0 immediately; no stale result appears after deassert; the next op 3+4 gives sum=7 with normal 4-cycle latency.
